// File: rtl/multicycle_controller_pkg.sv
// Shared state/opcode encodings for the multicycle controller and its output decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM_WAIT,
        WB,
        HALT
    } ctrlState_t;

    typedef enum logic [2:0] {
        K_NOP,
        K_ALU,
        K_MOVI,
        K_LOAD,
        K_STORE,
        K_JUMP,
        K_HALT,
        K_ILLEGAL
    } opKind_t;

    localparam int unsigned OP_NOP   = 0;
    localparam int unsigned OP_ADD   = 1;
    localparam int unsigned OP_SUB   = 2;
    localparam int unsigned OP_AND   = 3;
    localparam int unsigned OP_OR    = 4;
    localparam int unsigned OP_LOAD  = 5;
    localparam int unsigned OP_STORE = 6;
    localparam int unsigned OP_JMP   = 7;
    localparam int unsigned OP_JZ    = 8;
    localparam int unsigned OP_MOVI  = 9;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // HALT is the all-ones opcode, so its value follows the opcode width.
    function automatic int unsigned opHaltValue(input int unsigned opw);
        return (32'd1 << opw) - 32'd1;
    endfunction

    function automatic opKind_t classifyOp(input int unsigned op, input int unsigned haltOp);
        if (op == haltOp) return K_HALT;
        if (op == OP_NOP) return K_NOP;
        if (op <= OP_OR) return K_ALU;
        if (op == OP_LOAD) return K_LOAD;
        if (op == OP_STORE) return K_STORE;
        if (op == OP_JMP || op == OP_JZ) return K_JUMP;
        if (op == OP_MOVI) return K_MOVI;
        return K_ILLEGAL;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> IR/datapath bundle; master is the controller, slave the datapath side.
interface multicycle_controller_if #(
    parameter int OPW  = 4,
    parameter int NREG = 3,
    parameter int RSW  = 2
);
    logic            en;
    logic [OPW-1:0]  opcode;
    logic [RSW-1:0]  rsel;
    logic            zero;
    logic            mem_ready;
    logic [NREG-1:0] load_reg;
    logic            loadIR;
    logic            loadPC;
    logic            incPC;
    logic [1:0]      alu_mode;
    logic            we_DM;
    logic            re_DM;
    logic            selA;
    logic            selB;
    logic            halted;
    logic            err;

    modport master (
        input  en, opcode, rsel, zero, mem_ready,
        output load_reg, loadIR, loadPC, incPC, alu_mode,
               we_DM, re_DM, selA, selB, halted, err
    );

    modport slave (
        output en, opcode, rsel, zero, mem_ready,
        input  load_reg, loadIR, loadPC, incPC, alu_mode,
               we_DM, re_DM, selA, selB, halted, err
    );
endinterface

// File: rtl/multicycle_controller_out_decode.sv
// Purely combinational map from controller state and latched instruction to datapath controls.
module ctrl_out_decode
    import ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int NREG = 3,
    parameter int RSW  = 2
) (
    input  ctrlState_t      state,
    input  logic [OPW-1:0]  op_q,
    input  logic [RSW-1:0]  rs_q,
    input  logic            zero,
    output logic [NREG-1:0] load_reg,
    output logic            loadIR,
    output logic            loadPC,
    output logic            incPC,
    output logic [1:0]      alu_mode,
    output logic            we_DM,
    output logic            re_DM,
    output logic            selA,
    output logic            selB,
    output logic            halted,
    output logic            badDest
);
    int unsigned opVal;
    opKind_t     kind;
    logic [1:0]  aluOf;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        load_reg = '0;
        loadIR   = 1'b0;
        loadPC   = 1'b0;
        incPC    = 1'b0;
        alu_mode = ALU_ADD;
        we_DM    = 1'b0;
        re_DM    = 1'b0;
        selA     = 1'b0;
        selB     = 1'b0;
        halted   = 1'b0;
        badDest  = 1'b0;
        opVal    = 32'(op_q);
        kind     = classifyOp(opVal, opHaltValue(OPW));
        aluOf    = 2'(opVal - 32'd1);

        case (state)
            FETCH: begin
                loadIR = 1'b1;
                incPC  = 1'b1;
            end
            EXEC: begin
                if (kind == K_ALU) alu_mode = aluOf;
                selB = (kind == K_MOVI);
                if (kind == K_JUMP) loadPC = (opVal == OP_JMP) ? 1'b1 : zero;
            end
            MEM_WAIT: begin
                re_DM = (kind == K_LOAD);
                selA  = (kind == K_LOAD);
                we_DM = (kind == K_STORE);
            end
            WB: begin
                // An out-of-range destination simply matches no load bit.
                for (int i = 0; i < NREG; i++) load_reg[i] = (int'(rs_q) == i);
                badDest = (int'(rs_q) >= NREG);
                selA    = (kind == K_LOAD);
                selB    = (kind == K_MOVI);
                if (kind == K_ALU) alu_mode = aluOf;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencer: FSM, instruction latch, memory-wait counter and sticky error flag.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int NREG        = 3,
    parameter int RSW         = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                    clk,
    input logic                    rst,
    multicycle_controller_if.master bus
);
    ctrlState_t     state;
    ctrlState_t     stateNext;
    ctrlState_t     boundary;
    logic [OPW-1:0] op_q;
    logic [RSW-1:0] rs_q;
    logic [7:0]     waitCnt;
    logic           errQ;
    logic           setErr;
    logic           badDest;
    opKind_t        irKind;
    opKind_t        opKind;

    ctrl_out_decode #(.OPW(OPW), .NREG(NREG), .RSW(RSW)) uDecode (
        .state    (state),
        .op_q     (op_q),
        .rs_q     (rs_q),
        .zero     (bus.zero),
        .load_reg (bus.load_reg),
        .loadIR   (bus.loadIR),
        .loadPC   (bus.loadPC),
        .incPC    (bus.incPC),
        .alu_mode (bus.alu_mode),
        .we_DM    (bus.we_DM),
        .re_DM    (bus.re_DM),
        .selA     (bus.selA),
        .selB     (bus.selB),
        .halted   (bus.halted),
        .badDest  (badDest)
    );

    always_comb begin
        stateNext = state;
        setErr    = 1'b0;
        boundary  = bus.en ? FETCH : IDLE;
        irKind    = classifyOp(32'(bus.opcode), opHaltValue(OPW));
        opKind    = classifyOp(32'(op_q), opHaltValue(OPW));

        case (state)
            IDLE:   if (bus.en) stateNext = FETCH;
            FETCH:  stateNext = DECODE;
            DECODE: begin
                case (irKind)
                    K_NOP:                   stateNext = boundary;
                    K_ALU, K_MOVI, K_JUMP:   stateNext = EXEC;
                    K_LOAD, K_STORE:         stateNext = MEM_WAIT;
                    K_HALT:                  stateNext = HALT;
                    default: begin
                        stateNext = HALT;
                        setErr    = 1'b1;
                    end
                endcase
            end
            EXEC: stateNext = (opKind == K_ALU || opKind == K_MOVI) ? WB : boundary;
            MEM_WAIT: begin
                // Timeout is tested first so a same-edge mem_ready still halts.
                if (waitCnt == 8'(MEM_TIMEOUT - 1)) begin
                    stateNext = HALT;
                    setErr    = 1'b1;
                end else if (bus.mem_ready) begin
                    stateNext = (opKind == K_LOAD) ? WB : boundary;
                end
            end
            WB: begin
                stateNext = boundary;
                setErr    = badDest;
            end
            default: stateNext = HALT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            rs_q    <= '0;
            waitCnt <= '0;
            errQ    <= 1'b0;
        end else begin
            state   <= stateNext;
            errQ    <= errQ | setErr;
            waitCnt <= (state == MEM_WAIT) ? waitCnt + 8'd1 : 8'd0;
            if (state == DECODE) begin
                op_q <= bus.opcode;
                rs_q <= bus.rsel;
            end
        end
    end

    assign bus.err = errQ;
endmodule
